// File: rtl/fetch_bus_responder_if.sv
// Fetch-side read bus between the instruction fetch initiator and its responder.
// bus_read_error exists only when FETCH_BUS_RESPONDER_ERROR_EN is defined.
interface fetch_bus_responder_if;
  logic        bus_read_vaild;
  logic [31:0] bus_read_address;
  logic        bus_read_ready;
  logic [31:0] bus_read_data;
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
  logic        bus_read_error;
`endif

  modport master (
    output bus_read_vaild, bus_read_address,
    input  bus_read_ready, bus_read_data
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
    , input bus_read_error
`endif
  );

  modport slave (
    input  bus_read_vaild, bus_read_address,
    output bus_read_ready, bus_read_data
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
    , output bus_read_error
`endif
  );
endinterface

// File: rtl/fetch_bus_responder.sv
// Read-only fetch bus responder backed by a word memory with WAIT_STATES latency and a load port.
// Optional FETCH_BUS_RESPONDER_ERROR_EN: out-of-range reads answer with an error, out-of-range loads drop.
module fetch_bus_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic                        clock,
  input  logic                        reset,
  fetch_bus_responder_if.slave        bus,
  input  logic                        load_valid,
  input  logic [31:0]                 load_address,
  input  logic [31:0]                 load_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t        state, state_n;
  logic [3:0]    cnt;
  logic [31:0]   word_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_idx, ld_idx;
  logic [31:0]   fetch_word;
  logic          capture;

  assign rd_idx  = bus.bus_read_address[AW+1:2];
  assign ld_idx  = load_address[AW+1:2];
  assign capture = (state == S_IDLE) && bus.bus_read_vaild;

`ifdef FETCH_BUS_RESPONDER_ERROR_EN
  logic rd_oob, ld_oob, err_q;
  logic unused_addr_bits;
  assign rd_oob           = |bus.bus_read_address[31:AW+2];
  assign ld_oob           = |load_address[31:AW+2];
  assign fetch_word       = rd_oob ? 32'hFFFF_FFFF : mem[rd_idx];
  assign unused_addr_bits = ^{bus.bus_read_address[1:0], load_address[1:0]};
`else
  logic unused_addr_bits;
  assign fetch_word       = mem[rd_idx];
  assign unused_addr_bits = ^{bus.bus_read_address[1:0], bus.bus_read_address[31:AW+2],
                              load_address[1:0], load_address[31:AW+2]};
`endif

  // NOTE: memory has no reset; clearing it would cost a write port sweep and lose boot images.
  always_ff @(posedge clock) begin
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
    if (load_valid && !ld_oob) mem[ld_idx] <= load_data;
`else
    if (load_valid) mem[ld_idx] <= load_data;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // NOTE: state_n gets its default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (bus.bus_read_vaild) state_n = (WS == 4'd0) ? S_RESPOND : S_WAIT;
      end
      S_WAIT: begin
        if (!bus.bus_read_vaild) state_n = S_IDLE;
        else if (cnt == 4'd1)    state_n = S_RESPOND;
      end
      S_RESPOND: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // The word is read on the capture edge, so a load on that same edge is seen only by later reads.
  // NOTE: non-blocking reads of mem here sample the pre-edge contents, giving read-before-write.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt                <= 4'd0;
      word_q             <= 32'd0;
      bus.bus_read_ready <= 1'b0;
      bus.bus_read_data  <= 32'd0;
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
      err_q              <= 1'b0;
      bus.bus_read_error <= 1'b0;
`endif
    end else begin
      bus.bus_read_ready <= (state_n == S_RESPOND);
      if (state_n == S_RESPOND)
        bus.bus_read_data <= (state == S_IDLE) ? fetch_word : word_q;
      else
        bus.bus_read_data <= 32'd0;
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
      bus.bus_read_error <= (state_n == S_RESPOND) && ((state == S_IDLE) ? rd_oob : err_q);
`endif
      if (capture) begin
        cnt    <= WS;
        word_q <= fetch_word;
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
        err_q  <= rd_oob;
`endif
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_bus_responder.sv
// Self-checking bench: two responders (WAIT_STATES 0 and 2) sharing one load port, checked against
// a flat array model of memory contents and the latency rule WAIT_STATES+1.
module tb_fetch_bus_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_address;
  logic [31:0] load_data;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_mem [DEPTH];

  fetch_bus_responder_if bus0 ();
  fetch_bus_responder_if bus2 ();

  fetch_bus_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave),
    .load_valid(load_valid), .load_address(load_address), .load_data(load_data)
  );

  fetch_bus_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2.slave),
    .load_valid(load_valid), .load_address(load_address), .load_data(load_data)
  );

  always #5 clock = ~clock;

  function automatic bit oob(input logic [31:0] a);
    return a[31:AW+2] != '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (ERR_EN && oob(a)) return 32'hFFFF_FFFF;
    return ref_mem[a[AW+1:2]];
  endfunction

  task automatic model_load(input logic [31:0] a, input logic [31:0] d);
    if (!(ERR_EN && oob(a))) ref_mem[a[AW+1:2]] = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic [31:0] a);
    if (sel == 0) begin bus0.bus_read_vaild = v; bus0.bus_read_address = a; end
    else          begin bus2.bus_read_vaild = v; bus2.bus_read_address = a; end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.bus_read_ready : bus2.bus_read_ready;
  endfunction

  function automatic logic [31:0] get_data(input int sel);
    return (sel == 0) ? bus0.bus_read_data : bus2.bus_read_data;
  endfunction

`ifdef FETCH_BUS_RESPONDER_ERROR_EN
  function automatic logic get_error(input int sel);
    return (sel == 0) ? bus0.bus_read_error : bus2.bus_read_error;
  endfunction
`endif

  // All tasks start and end just after a falling edge.
  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_valid = 1'b1; load_address = a; load_data = d;
    @(negedge clock);
    load_valid = 1'b0;
    model_load(a, d);
  endtask

  task automatic read_txn(input int sel, input logic [31:0] a, input string tag,
                          input bit with_load = 1'b0, input logic [31:0] ld_d = 32'd0);
    int          n = 0;
    logic [31:0] exp = model_read(a);
    bit          exp_err = ERR_EN && oob(a);
    set_req(sel, 1'b1, a);
    if (with_load) begin load_valid = 1'b1; load_address = a; load_data = ld_d; end
    do begin
      @(negedge clock);
      n++;
      if (n == 1 && with_load) begin load_valid = 1'b0; model_load(a, ld_d); end
    end while (!get_ready(sel) && n < 20);
    check({tag, "_latency"}, 32'(n), 32'((sel == 0) ? 1 : 3));
    check({tag, "_data"}, get_data(sel), exp);
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
    check({tag, "_error"}, 32'(get_error(sel)), 32'(exp_err));
`else
    if (exp_err) $display("unexpected error expectation for %s", tag);
`endif
    set_req(sel, 1'b0, a);
    @(negedge clock);
    check({tag, "_ready_clear"}, 32'(get_ready(sel)), 32'd0);
    check({tag, "_data_clear"}, get_data(sel), 32'd0);
  endtask

  initial begin
    int          seen;
    logic [31:0] a, d;

    reset = 1'b1; load_valid = 1'b0; load_address = '0; load_data = '0;
    set_req(0, 1'b0, 32'd0);
    set_req(2, 1'b0, 32'd0);
    @(negedge clock);
    check("reset_ready0", 32'(bus0.bus_read_ready), 32'd0);
    check("reset_data0", bus0.bus_read_data, 32'd0);
    check("reset_ready2", 32'(bus2.bus_read_ready), 32'd0);
    check("reset_data2", bus2.bus_read_data, 32'd0);

    // Fill the whole memory while still in reset: loads must work there too.
    for (int i = 0; i < DEPTH; i++) do_load(32'(i * 4), $urandom);
    reset = 1'b0;
    @(negedge clock);

    // Basic read, two wait states.
    do_load(32'h20, 32'h0001_1011);
    read_txn(2, 32'h20, "basic_ws2");

    // Back-to-back with valid held high, zero wait states.
    do_load(32'h0, 32'd1);
    do_load(32'h4, 32'd2);
    do_load(32'h8, 32'd3);
    set_req(0, 1'b1, 32'h0);
    @(negedge clock);
    check("b2b_rdy_a", 32'(bus0.bus_read_ready), 32'd1);
    check("b2b_data_a", bus0.bus_read_data, 32'd1);
    set_req(0, 1'b1, 32'h4);
    @(negedge clock);
    check("b2b_gap_a", 32'(bus0.bus_read_ready), 32'd0);
    @(negedge clock);
    check("b2b_rdy_b", 32'(bus0.bus_read_ready), 32'd1);
    check("b2b_data_b", bus0.bus_read_data, 32'd2);
    set_req(0, 1'b1, 32'h8);
    @(negedge clock);
    check("b2b_gap_b", 32'(bus0.bus_read_ready), 32'd0);
    @(negedge clock);
    check("b2b_rdy_c", 32'(bus0.bus_read_ready), 32'd1);
    check("b2b_data_c", bus0.bus_read_data, 32'd3);
    set_req(0, 1'b0, 32'h0);
    @(negedge clock);
    check("b2b_end", 32'(bus0.bus_read_ready), 32'd0);

    // Abandon in the first WAIT cycle.
    set_req(2, 1'b1, 32'h20);
    @(negedge clock);
    set_req(2, 1'b0, 32'h20);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus2.bus_read_ready) seen++;
    end
    check("abandon_no_ready", 32'(seen), 32'd0);
    read_txn(2, 32'h20, "after_abandon");

    // Reset during WAIT, with a load issued while reset is asserted.
    set_req(2, 1'b1, 32'h20);
    @(negedge clock);
    reset = 1'b1;
    load_valid = 1'b1; load_address = 32'h40; load_data = 32'hA5A5_0040;
    @(negedge clock);
    check("rst_wait_ready", 32'(bus2.bus_read_ready), 32'd0);
    check("rst_wait_data", bus2.bus_read_data, 32'd0);
`ifdef FETCH_BUS_RESPONDER_ERROR_EN
    check("rst_wait_error", 32'(bus2.bus_read_error), 32'd0);
`endif
    load_valid = 1'b0;
    model_load(32'h40, 32'hA5A5_0040);
    set_req(2, 1'b0, 32'h20);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus2.bus_read_ready) seen++;
    end
    check("rst_no_ready", 32'(seen), 32'd0);
    read_txn(2, 32'h20, "rst_mem_kept");
    read_txn(0, 32'h40, "load_in_reset");

    // Same-edge load and capture: old data first, new data afterwards.
    read_txn(0, 32'h20, "collide", 1'b1, 32'hDEAD_BEEF);
    read_txn(0, 32'h20, "collide_after");

    // Out-of-range handling (error response or wrap depending on build).
    read_txn(2, 32'h0000_1020, "oob_read");
    do_load(32'h0000_1044, 32'h1234_5678);
    read_txn(0, 32'h44, "oob_load");

    // Randomized loads and reads against the array model.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[31:AW+2] = '0;
      d = $urandom;
      if ($urandom_range(1) == 1) do_load(a, d);
      a = $urandom;
      if ($urandom_range(3) != 0) a[31:AW+2] = '0;
      read_txn(($urandom_range(1) == 1) ? 2 : 0, a, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
